stream_fifo: RTL
================

STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning data bits per entry.
REQ-002 SHALL have parameter DEPTH, default 8, meaning entry count; power of two, >= 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, meaning almost_full threshold; 1..DEPTH.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous clear of all entries.
REQ-007 SHALL have port in_valid  input  1  producer offers in_data.
REQ-008 SHALL have port in_ready  output  1  FIFO accepts a write this cycle.
REQ-009 SHALL have port in_data  input  WIDTH  write data.
REQ-010 SHALL have port out_valid  output  1  out_data holds the oldest entry.
REQ-011 SHALL have port out_ready  input  1  consumer takes out_data.
REQ-012 SHALL have port out_data  output  WIDTH  oldest entry (first-word fall-through).
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.
REQ-014 SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-015 SHALL have port overflow  output  1  sticky: write attempted while full.

Function
REQ-016 Push SHALL occur on a rising edge when in_valid && in_ready && !flush.
REQ-017 Pop SHALL occur on a rising edge when out_valid && out_ready && !flush.
REQ-018 in_ready SHALL be !full, registered-state only; no combinational path from out_ready or in_valid.
REQ-019 out_valid SHALL be (count != 0); out_data SHALL equal storage at read pointer, combinationally.
REQ-020 Latency: an entry pushed at edge N SHALL appear on out_data/out_valid after edge N (usable cycle N+1).
REQ-021 Order SHALL be strict FIFO; no entry lost, duplicated or reordered.
REQ-022 Read/write pointers SHALL be log2(DEPTH)+1 bits; MSB is the wrap bit; empty = pointers equal; full = low bits equal, MSB differs.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 in the low bits, toggling the wrap bit.
REQ-024 count SHALL be +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-025 Simultaneous push and pop at 0 < count < DEPTH SHALL keep count and advance both pointers.
REQ-026 When full, in_ready = 0, so a pop and an in_valid in the same cycle SHALL NOT push; count becomes DEPTH-1.
REQ-027 When empty, out_valid = 0, so a push and an out_ready in the same cycle SHALL NOT pop; count becomes 1.
REQ-028 flush SHALL zero both pointers and count at the next edge, overriding push and pop in that cycle; storage contents are not cleared.
REQ-029 overflow SHALL set on an edge where in_valid && !in_ready && !flush, and SHALL clear only on reset or flush.
REQ-030 almost_full SHALL be registered and consistent with count in the same cycle.

Reset
REQ-031 On rst_n low, pointers, count, almost_full and overflow SHALL go to 0 immediately (asynchronously).
REQ-032 Storage SHALL reset to all zeros, so out_data = 0, out_valid = 0 and in_ready = 1 during and after reset.
REQ-033 Reset asserted mid-transfer SHALL discard all contents; no partial push or pop takes effect.

Structure
REQ-034 Package stream_fifo_pkg SHALL hold the pointer-width and count-width helper functions and the default WIDTH/DEPTH constants.
REQ-035 Storage SHALL be a sub-module fifo_mem: DEPTH x WIDTH array, one synchronous write port, one asynchronous read port, async reset to zero.
REQ-036 Control (pointers, count, flags) SHALL live in stream_fifo itself.

Verification
REQ-037 Reset, then push 0x11 with out_ready = 0 -> next cycle out_valid = 1, out_data = 0x11, count = 1.
REQ-038 DEPTH = 8: push 8 words 1..8 -> in_ready = 0, count = 8, almost_full = 1 from count 6; a 9th in_valid sets overflow = 1, and 1..8 then pop in order.
REQ-039 Full FIFO with in_valid = 1 and out_ready = 1 for one cycle -> word 1 popped, nothing pushed, count = 7.
REQ-040 Streaming with in_valid = out_ready = 1 for 20 cycles from count 3 -> count stays 3, pointers wrap twice, output sequence is continuous.
REQ-041 count = 5 with flush and in_valid high -> next cycle count = 0, out_valid = 0, overflow = 0, and the offered word is dropped.
REQ-042 rst_n pulsed low mid-stream at count = 4 -> count = 0, out_data = 0, in_ready = 1 immediately, and the stream restarts cleanly.

Source files
------------

// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg
// Shared constants and sizing helpers for the stream FIFO.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and entry count
//   ptr_width(depth)              : read/write pointer width (index bits + wrap bit)
//   cnt_width(depth)              : occupancy counter width (must represent 0..depth)
package stream_fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 64;
    localparam int unsigned DEFAULT_DEPTH = 8;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
// DEPTH x WIDTH storage array for stream_fifo.
//   clk, rst_n : clock, asynchronous active-low reset (clears every entry to zero)
//   we         : write enable, synchronous write of wdata at waddr
//   waddr      : write index
//   wdata      : write data
//   raddr      : read index
//   rdata      : asynchronous (combinational) read of entry raddr
module fifo_mem #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo
// First-word fall-through valid/ready FIFO with occupancy count and status flags.
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   flush       : synchronous clear of pointers and count (storage untouched)
//   in_valid    : producer offers in_data
//   in_ready    : FIFO can accept a write (not full)
//   in_data     : write data
//   out_valid   : out_data holds the oldest entry
//   out_ready   : consumer takes out_data
//   out_data    : oldest entry, read combinationally from storage
//   count       : current occupancy
//   almost_full : registered, count >= AF_LEVEL
//   overflow    : sticky, a write was offered while full (cleared by reset or flush)
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        almost_full,
    output logic                        overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_next;

    // Full when the index bits match but the wrap bits differ; derived from
    // registered pointers only, so in_ready has no path from in_valid/out_ready.
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign in_ready  = !full;
    assign out_valid = (count != '0);

    assign push = in_valid  && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            count       <= count_next;
            // Registered from the next count so the flag always agrees with count.
            almost_full <= (count_next >= CW'(AF_LEVEL));
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                // DEPTH is a power of two: plain increment wraps the index bits
                // and toggles the wrap bit.
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (in_valid && !in_ready) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (out_data)
    );

endmodule
